sm4_crypt_top: RTL and testbench
================================

SM4_CRYPT_TOP -- requirements
Module: sm4_crypt_top

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, meaning number of SM4 rounds and round-key words read per block.
REQ-002 SHALL have port crypt_top_clk  input  1  sole clock; all flops rise-edge.
REQ-003 SHALL have port crypt_top_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port crypt_top_begin  input  1  start request, sampled each clock edge.
REQ-005 SHALL have port decrypt  input  1  mode: 0 encrypt, 1 decrypt; sampled at accept.
REQ-006 SHALL have port data_in  input  [0:127]  block; [0:31]=X0 through [96:127]=X3; sampled at accept.
REQ-007 SHALL have port rk_complete  input  1  key schedule finished; key RAM holds rk0..rk31 at addresses 0..31.
REQ-008 SHALL have port rk_data  input  [0:31]  key RAM read data.
REQ-009 SHALL have port rk_rd_en  output  1  key RAM read enable, registered.
REQ-010 SHALL have port rk_rd_addr  output  [0:4]  key RAM read address, registered.
REQ-011 SHALL have port data_out  output  [0:127]  result block, registered, held until next result.
REQ-012 SHALL have port crypt_top_busy  output  1  high from accept until result cycle.
REQ-013 SHALL have port crypt_top_complete  output  1  one-cycle pulse, data_out valid.

Function
REQ-014 SHALL use states IDLE, FETCH, ROUND; IDLE->FETCH on crypt_top_begin&&rk_complete; FETCH->ROUND always; ROUND->IDLE after round ROUNDS-1.
REQ-015 SHALL ignore crypt_top_begin when rk_complete=0 (stay IDLE, no read issued) and whenever state is not IDLE.
REQ-016 SHALL on accept load X0..X3 from data_in, latch decrypt, set round counter 0.
REQ-017 SHALL, in cycle k after accept (k=1..32), drive rk_rd_en=1 and rk_rd_addr = k-1 (encrypt) or 32-k (decrypt); rk_rd_en=0 in all other cycles.
REQ-018 SHALL treat rk_data sampled at the edge ending cycle k+1 as the key for the address driven in cycle k (one-cycle RAM read latency).
REQ-019 SHALL per ROUND edge compute Xnew = X0 ^ T(X1^X2^X3^rk_data), shift (X0,X1,X2,X3)<=(X1,X2,X3,Xnew).
REQ-020 SHALL define T(A) = L(tau(A)), tau = four parallel standard SM4 S-box bytes, L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24, all 32-bit rotates.
REQ-021 SHALL at the final round edge (edge ending cycle 33) load data_out = {X35,X34,X33,X32} (reverse order), pulse crypt_top_complete high for cycle 34, drop crypt_top_busy, return to IDLE.
REQ-022 SHALL give latency 34 cycles from accept edge to complete pulse, one block per 34 cycles.
REQ-023 SHALL accept crypt_top_begin sampled during the complete cycle (back-to-back), next block's rk_rd_en asserting the following cycle.
REQ-024 SHALL not re-check rk_complete after accept; mid-block changes have no effect.

Reset
REQ-025 SHALL on crypt_top_rst=1, immediately and regardless of state: state IDLE, rk_rd_en=0, rk_rd_addr=0, data_out=0, crypt_top_busy=0, crypt_top_complete=0, X registers and counter 0.
REQ-026 SHALL on reset mid-block discard the block, emit no complete pulse, and accept a new begin on the first edge after reset deasserts.

Structure
REQ-027 SHALL place state encodings, the 256-entry S-box table and ROUNDS in shared package sm4_pkg, also used by the key-schedule block.
REQ-028 SHALL implement T in combinational sub-module sm4_t_function (32-bit in, 32-bit out); round registers and FSM stay in sm4_crypt_top.

Verification
REQ-029 SHALL test encrypt: key RAM from MK 0123456789abcdeffedcba9876543210 (rk0=f12186f9, rk31=9124a012), data_in same value, decrypt=0 -> data_out 681edf34d206965e86b3e94f536e4246, complete 34 cycles after accept.
REQ-030 SHALL test decrypt: same keys, data_in 681edf34d206965e86b3e94f536e4246, decrypt=1 -> data_out 0123456789abcdeffedcba9876543210, addresses observed 31 down to 0.
REQ-031 SHALL test back-to-back: begin held high across two blocks -> two complete pulses exactly 34 cycles apart, both results correct.
REQ-032 SHALL test gating: begin=1 with rk_complete=0 for 10 cycles -> rk_rd_en stays 0, no complete; begin pulses while busy -> ignored, single result.
REQ-033 SHALL test reset at round 15 -> all outputs 0 asynchronously, no complete pulse; subsequent encrypt yields 681edf34d206965e86b3e94f536e4246.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: FSM encodings, the standard S-box, round count
// and small helpers used by the cipher datapath and the key schedule.
package sm4_pkg;

  localparam int SM4_ROUNDS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ROUND = 2'd2
  } sm4_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

endpackage

// File: rtl/sm4_t_function.sv
// SM4 round transform T(A) = L(tau(A)): byte-wise S-box substitution
// followed by the cipher's linear diffusion layer. Purely combinational.
module sm4_t_function
  import sm4_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] t
);

  logic [31:0] b;

  // Substitute each byte, then mix with the four fixed rotations
  always_comb begin
    b = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    t = b ^ rotl32(b, 2) ^ rotl32(b, 10) ^ rotl32(b, 18) ^ rotl32(b, 24);
  end

endmodule

// File: rtl/sm4_crypt_top.sv
// Iterative SM4 block cipher core. One round per clock, round keys streamed
// from an external key RAM with one cycle of read latency: the FETCH cycle
// covers that latency so each ROUND edge sees the key it needs on rk_data.
module sm4_crypt_top
  import sm4_pkg::*;
#(
  parameter int ROUNDS = SM4_ROUNDS
) (
  input  logic         crypt_top_clk,
  input  logic         crypt_top_rst,
  input  logic         crypt_top_begin,
  input  logic         decrypt,
  input  logic [0:127] data_in,
  input  logic         rk_complete,
  input  logic [0:31]  rk_data,
  output logic         rk_rd_en,
  output logic [0:4]   rk_rd_addr,
  output logic [0:127] data_out,
  output logic         crypt_top_busy,
  output logic         crypt_top_complete
);

  localparam int CW = $clog2(ROUNDS);

  sm4_state_t    state;
  logic [31:0]   x0, x1, x2, x3;
  logic          dec;
  logic [CW-1:0] cnt;
  logic [31:0]   t_in, t_out, xnew;

  assign t_in = x1 ^ x2 ^ x3 ^ rk_data;
  assign xnew = x0 ^ t_out;

  sm4_t_function u_t (
    .a (t_in),
    .t (t_out)
  );

  // Control FSM, key address sequencing and the round register shift
  always_ff @(posedge crypt_top_clk or posedge crypt_top_rst) begin
    if (crypt_top_rst) begin
      state              <= IDLE;
      x0                 <= '0;
      x1                 <= '0;
      x2                 <= '0;
      x3                 <= '0;
      dec                <= 1'b0;
      cnt                <= '0;
      rk_rd_en           <= 1'b0;
      rk_rd_addr         <= '0;
      data_out           <= '0;
      crypt_top_busy     <= 1'b0;
      crypt_top_complete <= 1'b0;
    end else begin
      crypt_top_complete <= 1'b0;
      case (state)
        IDLE: begin
          // rk_complete only gates acceptance; it is not looked at again
          if (crypt_top_begin && rk_complete) begin
            x0             <= data_in[0:31];
            x1             <= data_in[32:63];
            x2             <= data_in[64:95];
            x3             <= data_in[96:127];
            dec            <= decrypt;
            cnt            <= '0;
            rk_rd_en       <= 1'b1;
            rk_rd_addr     <= decrypt ? 5'(ROUNDS - 1) : 5'd0;
            crypt_top_busy <= 1'b1;
            state          <= FETCH;
          end
        end
        FETCH: begin
          rk_rd_en   <= 1'b1;
          rk_rd_addr <= dec ? rk_rd_addr - 5'd1 : rk_rd_addr + 5'd1;
          state      <= ROUND;
        end
        ROUND: begin
          x0  <= x1;
          x1  <= x2;
          x2  <= x3;
          x3  <= xnew;
          cnt <= cnt + 1'b1;
          // Reads run two rounds ahead of the datapath
          if (int'(cnt) < ROUNDS - 2) begin
            rk_rd_en   <= 1'b1;
            rk_rd_addr <= dec ? rk_rd_addr - 5'd1 : rk_rd_addr + 5'd1;
          end else begin
            rk_rd_en <= 1'b0;
          end
          if (cnt == CW'(ROUNDS - 1)) begin
            data_out           <= {xnew, x3, x2, x1};
            crypt_top_complete <= 1'b1;
            crypt_top_busy     <= 1'b0;
            state              <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_crypt_top.sv
// Scoreboard bench for sm4_crypt_top: stimulus pushes expected blocks,
// a negedge monitor models the control timeline and checks every cycle.
module tb_sm4_crypt_top;
  import sm4_pkg::*;

  localparam logic [127:0] PT = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT = 128'h681edf34d206965e86b3e94f536e4246;

  logic         clk;
  logic         rst;
  logic         start;
  logic         decrypt;
  logic [0:127] data_in;
  logic         rk_complete;
  logic [0:31]  rk_data;
  logic         rk_rd_en;
  logic [0:4]   rk_rd_addr;
  logic [0:127] data_out;
  logic         busy;
  logic         complete;

  logic [31:0]  rk_mem [32];
  logic [127:0] exp_q [$];
  int           comp_cyc [$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           in_block = 0;
  int           start_cyc = 0;
  logic         blk_dec = 1'b0;

  sm4_crypt_top dut (
    .crypt_top_clk      (clk),
    .crypt_top_rst      (rst),
    .crypt_top_begin    (start),
    .decrypt            (decrypt),
    .data_in            (data_in),
    .rk_complete        (rk_complete),
    .rk_data            (rk_data),
    .rk_rd_en           (rk_rd_en),
    .rk_rd_addr         (rk_rd_addr),
    .data_out           (data_out),
    .crypt_top_busy     (busy),
    .crypt_top_complete (complete)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Key RAM with one cycle of read latency
  always @(posedge clk) begin
    if (rk_rd_en) rk_data <= rk_mem[rk_rd_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] t_key(input logic [31:0] a);
    logic [31:0] b;
    b = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
    return b ^ rotl32(b, 13) ^ rotl32(b, 23);
  endfunction

  task automatic build_keys(input logic [127:0] mk);
    logic [31:0] k0, k1, k2, k3, kn, ck;
    k0 = mk[127:96] ^ 32'ha3b1bac6;
    k1 = mk[95:64]  ^ 32'h56aa3350;
    k2 = mk[63:32]  ^ 32'h677d9197;
    k3 = mk[31:0]   ^ 32'hb27022dc;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
      kn = k0 ^ t_key(k1 ^ k2 ^ k3 ^ ck);
      rk_mem[i] = kn;
      k0 = k1; k1 = k2; k2 = k3; k3 = kn;
    end
  endtask

  // Monitor: independent timeline model, per-cycle control check, result pop
  initial begin : monitor
    int k;
    logic e_busy, e_en, e_comp;
    logic [4:0] e_addr, a_addr;
    logic [127:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_block = 0;
      end else begin
        k      = in_block ? cyc - start_cyc + 1 : 0;
        e_busy = (in_block != 0) && k <= 33;
        e_en   = (in_block != 0) && k >= 1 && k <= 32;
        e_comp = (in_block != 0) && k == 34;
        e_addr = blk_dec ? 5'(32 - k) : 5'(k - 1);
        a_addr = rk_rd_addr;
        chk("ctl{busy,en,complete,addr}",
            {124'd0, busy, rk_rd_en, complete, 5'(e_en ? a_addr : 5'd0)},
            {124'd0, e_busy, e_en, e_comp, 5'(e_en ? e_addr : 5'd0)});
        if (complete) comp_cyc.push_back(cyc);
        if (e_comp) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 128'd1, 128'd0);
          end else begin
            e = exp_q.pop_front();
            chk("data_out", data_out, e);
          end
        end
        if (in_block == 0 || k >= 34) begin
          in_block = 0;
          if (start && rk_complete) begin
            in_block  = 1;
            start_cyc = cyc + 1;
            blk_dec   = decrypt;
          end
        end
      end
    end
  end

  task automatic issue(input logic dec, input logic [127:0] din, input logic [127:0] exp);
    exp_q.push_back(exp);
    decrypt = dec;
    data_in = din;
    start   = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clk);
      n++;
    end
    #2;
    chk("result_arrived_in_time", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin : stimulus
    rst         = 1'b1;
    start       = 1'b0;
    decrypt     = 1'b0;
    data_in     = '0;
    rk_complete = 1'b0;
    rk_data     = '0;
    build_keys(PT);
    chk("rk0", 128'(rk_mem[0]), 128'h f12186f9);
    chk("rk31", 128'(rk_mem[31]), 128'h9124a012);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", data_out, 128'd0);
    chk("reset_ctl", {121'd0, busy, complete, rk_rd_en, rk_rd_addr}, 128'd0);
    #1 rst = 1'b0;
    rk_complete = 1'b1;
    @(posedge clk);
    #2;

    // Encrypt then decrypt the reference block
    issue(1'b0, PT, CT);
    wait_done(60);
    issue(1'b1, CT, PT);
    wait_done(60);

    // Back-to-back: begin held high across two accepts
    exp_q.push_back(CT);
    exp_q.push_back(PT);
    decrypt = 1'b0;
    data_in = PT;
    start   = 1'b1;
    @(posedge clk);
    #2;
    decrypt = 1'b1;
    data_in = CT;
    repeat (34) @(posedge clk);
    #2 start = 1'b0;
    wait_done(60);
    if (comp_cyc.size() >= 2)
      chk("b2b_spacing", 128'(comp_cyc[comp_cyc.size()-1] - comp_cyc[comp_cyc.size()-2]), 128'd34);
    else
      chk("b2b_pulse_count", 128'(comp_cyc.size()), 128'd2);

    // Gating: begin without a finished key schedule is ignored
    rk_complete = 1'b0;
    start       = 1'b1;
    repeat (10) @(posedge clk);
    #2 start = 1'b0;
    rk_complete = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Begin pulses while busy and a mid-block rk_complete drop are ignored
    issue(1'b0, PT, CT);
    repeat (4) @(posedge clk);
    #2 start = 1'b1;
    decrypt = 1'b1;
    rk_complete = 1'b0;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    rk_complete = 1'b1;
    wait_done(60);
    repeat (40) @(posedge clk);
    #2;

    // Reset at round 15, then restart on the first edge after release
    issue(1'b0, PT, CT);
    repeat (16) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_data_out", data_out, 128'd0);
    chk("async_reset_ctl", {121'd0, busy, complete, rk_rd_en, rk_rd_addr}, 128'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    exp_q.push_back(CT);
    decrypt = 1'b0;
    data_in = PT;
    start   = 1'b1;
    rst     = 1'b0;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(60);
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
